// File: rtl/cubehash_seq.sv
// rtl/cubehash_seq.sv - CubeHash sponge sequencer driving one shared F8 permutation
// Optional capture counter on perm_count: define CUBEHASH_SEQ_PERM_CNT_EN.
module cubehash_seq #(
    parameter int PERM_LATENCY = 16,
    parameter int FINAL_PERMS  = 10,
    parameter int DIGEST_BITS  = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic [1023:0]          iv_in,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [255:0]           msg_data,
    input  logic                   msg_last,
    output logic [1023:0]          perm_in,
    input  logic [1023:0]          perm_out,
    output logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_valid,
    output logic                   busy,
    output logic [15:0]            perm_count
);
    typedef enum logic [2:0] {IDLE, ABSORB, PERM, FINAL, DONE} fsm_t;

    localparam logic [7:0]    LAT  = 8'(PERM_LATENCY);
    localparam logic [7:0]    FIN  = 8'(FINAL_PERMS);
    localparam logic [1023:0] FLIP = 1024'(1) << 992;

    fsm_t          fsm;
    logic [1023:0] state;
    logic [7:0]    cnt;
    logic [7:0]    fin;
    logic          last;

    // F8 sees the state register directly, so it stays stable while we count down
    assign perm_in = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm          <= IDLE;
            state        <= '0;
            cnt          <= '0;
            fin          <= '0;
            last         <= 1'b0;
            msg_ready    <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (init) begin
                        state        <= iv_in;
                        digest_valid <= 1'b0;
                        msg_ready    <= 1'b1;
                        busy         <= 1'b1;
                        fsm          <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (msg_valid) begin
                        state[255:0] <= state[255:0] ^ msg_data;
                        last         <= msg_last;
                        cnt          <= LAT;
                        msg_ready    <= 1'b0;
                        fsm          <= PERM;
                    end
                end
                PERM: begin
                    if (cnt == 8'd1) begin
                        if (last) begin
                            // finalization marker is applied once, before the final rounds
                            state <= perm_out ^ FLIP;
                            fin   <= FIN;
                            cnt   <= LAT;
                            fsm   <= FINAL;
                        end else begin
                            state     <= perm_out;
                            cnt       <= '0;
                            msg_ready <= 1'b1;
                            fsm       <= ABSORB;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                FINAL: begin
                    if (cnt == 8'd1) begin
                        state <= perm_out;
                        if (fin == 8'd1) begin
                            digest       <= perm_out[DIGEST_BITS-1:0];
                            digest_valid <= 1'b1;
                            busy         <= 1'b0;
                            cnt          <= '0;
                            fin          <= '0;
                            fsm          <= DONE;
                        end else begin
                            fin <= fin - 8'd1;
                            cnt <= LAT;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef CUBEHASH_SEQ_PERM_CNT_EN
    logic capture;
    assign capture = ((fsm == PERM) || (fsm == FINAL)) && (cnt == 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_count <= '0;
        end else if (capture) begin
            perm_count <= perm_count + 16'd1;
        end
    end
`else
    assign perm_count = '0;
`endif
endmodule

// File: doc/cubehash_seq.md
# cubehash_seq

Sponge sequencer for the CubeHash datapath: owns the 1024-bit chaining state, absorbs 256-bit message blocks, drives the shared F8 permutation instance through its `state_in`/`state_out` pair, runs the finalization permutations and presents the digest. It sits between the message front end and one F8 instance. F8 has no handshake, so this block holds the permutation input stable for a fixed number of cycles and then samples the output.

## Interface
Parameters:
- `PERM_LATENCY`, 16: cycles F8 needs from a stable `state_in` to a valid `state_out`; legal range 1..255.
- `FINAL_PERMS`, 10: number of F8 invocations in finalization; legal range 1..255.
- `DIGEST_BITS`, 512: digest width, taken from `state[DIGEST_BITS-1:0]`; legal range 8..1024.

Ports:
- `clk`, in, 1: the only clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `init`, in, 1: start a new hash and load `iv_in`.
- `iv_in`, in, 1024: initial chaining state.
- `msg_valid`, in, 1: a message block is offered.
- `msg_ready`, out, 1: the block accepts a message block.
- `msg_data`, in, 256: message block, XORed into `state[255:0]`.
- `msg_last`, in, 1: the offered block is the final block.
- `perm_in`, out, 1024: drives F8 `state_in`; always equals the state register.
- `perm_out`, in, 1024: F8 `state_out`.
- `digest`, out, DIGEST_BITS: hash result.
- `digest_valid`, out, 1: `digest` is valid.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `perm_count`, out, 16: number of completed permutation invocations (see Configuration).

## Operation
- Reset values:
  - state register = 0, so `perm_in` = 0.
  - `msg_ready` = 0, `digest` = 0, `digest_valid` = 0, `busy` = 0, `perm_count` = 0.
  - FSM = IDLE, down-counter = 0, final counter = 0.
- FSM states:
  - **IDLE**
    - `init` → state ← `iv_in`; go to ABSORB.
  - **ABSORB**
    - `msg_ready` = 1.
    - On `msg_valid & msg_ready` → state[255:0] ← state[255:0] ^ `msg_data`; latch `msg_last`; down-counter ← `PERM_LATENCY`; go to PERM.
  - **PERM**
    - The down-counter decrements each cycle.
    - When it reaches 1, the next edge captures state ← `perm_out`.
    - If the latched last flag is 0 → go to ABSORB.
    - If it is 1 → state ← `perm_out` ^ (1 << 992) (flip bit 0 of word 31); final counter ← `FINAL_PERMS`; down-counter ← `PERM_LATENCY`; go to FINAL.
  - **FINAL**
    - Same countdown as PERM.
    - Each capture does state ← `perm_out` and decrements the final counter.
    - The capture that brings the final counter to 0 also loads `digest` ← `perm_out[DIGEST_BITS-1:0]`, sets `digest_valid`, and goes to DONE.
  - **DONE**
    - `digest` and `digest_valid` hold.
    - `init` → `digest_valid` ← 0; state ← `iv_in`; go to ABSORB.
- `init` is ignored while `busy` = 1.
- `msg_valid` is ignored outside ABSORB.
- `perm_in` is unchanged for the whole countdown of every invocation.
- Simultaneous `init` and `msg_valid` in IDLE or DONE: only `init` takes effect; the message is not accepted in that cycle.
- `rst` mid-operation: everything aborts immediately to the reset values; a partial hash is never resumed.

## Timing
- `init` sampled at edge T → `msg_ready` = 1 from cycle T+1.
- Block accepted at edge E (non-last) → `msg_ready` = 0 during E+1..E+PERM_LATENCY; capture at edge E+PERM_LATENCY; `msg_ready` = 1 again in the following cycle. Earliest next accept is edge E+PERM_LATENCY+1.
- Last block accepted at edge E → `digest_valid` rises at edge E+(1+FINAL_PERMS)×PERM_LATENCY.
- With defaults, that is 176 cycles after acceptance.
- `PERM_LATENCY` = 1: one capture per cycle; the back-to-back absorb rate is one block per 2 cycles.

## Configuration
- `CUBEHASH_SEQ_PERM_CNT_EN`
  - Defined: `perm_count` increments on every capture in PERM and FINAL, clears only on `rst`, and wraps from 0xFFFF to 0.
  - Undefined: the counter is not built and `perm_count` is tied to 0.

## Test plan
The bench uses an identity F8 stub (`perm_out` = `perm_in`) with `PERM_LATENCY` = 4 and `FINAL_PERMS` = 2.
- Reset: drive `rst` = 1 mid-FINAL → all outputs return to reset values asynchronously; after `rst` falls, `busy` = 0 and `init` restarts cleanly.
- Single block: `iv_in` = 0x0200 in bits [15:0], `msg_data` = 0xAB, `msg_last` = 1 → `digest[15:0]` = 0x02AB and `digest_valid` rises exactly 12 cycles after acceptance.
- Two blocks with `msg_data` 0xF0 then 0x0F and `iv_in` = 0 → `digest[7:0]` = 0xFF. The second accept occurs no earlier than 5 cycles after the first.
- Backpressure and ignores:
  - Hold `msg_valid` high through PERM → exactly one block is absorbed per ABSORB visit.
  - `init` pulses while busy have no effect.
- Finalization bit: set `DIGEST_BITS` = 1024 and `iv_in` = 0, with one zero block → `digest` = 1 << 992 after 2 final invocations (odd flips are not cancelled, since the flip is applied once).
- With `CUBEHASH_SEQ_PERM_CNT_EN` defined, the two-block hash → `perm_count` = 4; without the macro → `perm_count` = 0.
